dense_layer_sequencer: RTL and testbench
========================================

Name: dense_layer_sequencer

Overview:
Time-multiplexed dense-layer engine. One signed multiply-accumulate unit is shared across all NUM_NEURONS neurons instead of one neuron instance per output. Weights and biases are streamed from an external synchronous ROM. It is a drop-in, area-reduced alternative to the parallel dense layer and sits between adjacent layers of the network pipeline, using the same inputs_ready/outputs_ready handshake.

Parameters:
DATA_WIDTH, 16, signed fixed-point word width for inputs, weights, biases and outputs
FRAC_BITS, 8, fractional bits of the Q format shared by all words
NUM_INPUTS, 16, inputs per neuron (>=1)
NUM_NEURONS, 16, neurons in the layer (>=1)
ACTIVATION, RELU, RELU or LINEAR (identity)

Ports:
clock  in  1  single clock; all state changes on the rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
inputs_ready  in  1  start request, sampled only in IDLE
inputs  in  NUM_INPUTS x DATA_WIDTH signed  layer input vector
weight_address  out  clog2(NUM_NEURONS*(NUM_INPUTS+1))  ROM word address
weight_read  out  1  ROM read enable
weight_data  in  DATA_WIDTH signed  ROM data, valid exactly one cycle after weight_read
outputs  out  NUM_NEURONS x DATA_WIDTH signed  activated neuron results
outputs_ready  out  1  one-cycle pulse when all outputs are updated
busy  out  1  high in every state except IDLE

Behaviour:
- ROM layout: neuron n occupies words n*(NUM_INPUTS+1) .. n*(NUM_INPUTS+1)+NUM_INPUTS.
  - Words 0..NUM_INPUTS-1 of a neuron hold the weights for inputs[0..NUM_INPUTS-1].
  - The last word holds the bias.
- Reset (reset=0, async): state IDLE; outputs all 0; outputs_ready 0; busy 0; weight_read 0; weight_address 0; accumulator 0; counters 0.
- FSM states: IDLE, RUN, FINISH, DONE.
- IDLE:
  - inputs_ready=1 at an edge latches inputs into an internal register, clears the accumulator, sets n=0 and k=0, and moves to RUN.
  - The inputs port is not sampled again until the next start.
- RUN:
  - Each cycle drives weight_read=1 and weight_address=n*(NUM_INPUTS+1)+k, then increments k.
  - After k=NUM_INPUTS has been issued, moves to FINISH.
- Delayed datapath (operates one cycle behind the address, tracked by a registered valid flag and k):
  - For a weight word: acc += (latched_input[k] * weight_data) >>> FRAC_BITS. The product is full 2*DATA_WIDTH; the shift is an arithmetic floor.
  - For the bias word: the bias is added unshifted.
  - Accumulator width: 2*DATA_WIDTH + clog2(NUM_INPUTS+1). It never wraps.
- FINISH (1 cycle, weight_read=0):
  - Absorbs the bias returned for the last address.
  - Writes outputs[n] = act(sat(acc)), where sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - ReLU maps negative results to 0; LINEAR passes the value through.
  - Clears acc. If n<NUM_NEURONS-1: n++, k=0, return to RUN. Otherwise go to DONE.
- DONE (1 cycle): outputs_ready=1, then return to IDLE.
- Per-neuron cost is NUM_INPUTS+2 cycles.
- Latency: with inputs_ready sampled at edge 0, outputs_ready is high during cycle NUM_NEURONS*(NUM_INPUTS+2)+1.
- outputs entries update only in FINISH. All other entries hold their previous values. Full vector is stable from DONE until the next run's first FINISH.
- inputs_ready while busy=1 is ignored and not queued. inputs_ready held high continuously starts a new run on the DONE->IDLE->RUN path: one idle cycle, then restart.
- inputs_ready asserted in the same cycle as DONE is ignored, because DONE is not IDLE.
- Reset mid-run aborts immediately: outputs are cleared to 0 and no outputs_ready pulse is produced.

Test Plan:
- Basic: DATA_WIDTH=16, FRAC_BITS=8, NUM_INPUTS=2, NUM_NEURONS=2, RELU.
  - inputs={256,512}; ROM={128,64,128, -256,0,0}.
  - Required: outputs={384,0}; outputs_ready pulse in cycle 9 only; busy high cycles 1-9.
- Address trace, same config: weight_address sequence 0,1,2 (cycles 1-3), read idle cycle 4, then 3,4,5 (cycles 5-7), read idle cycle 8.
- Saturation: inputs={32767,32767}, all weights 32767, bias 32767 -> outputs[0]=32767. LINEAR with all weights -32768 and inputs 32767 -> -32768.
- LINEAR negative: neuron 1 from the basic case with ACTIVATION=LINEAR -> outputs[1]=-256 (0xFF00).
- Busy-ignore: pulse inputs_ready at cycle 4 with different inputs -> results identical to the basic case, and no second run starts.
- Mid-run reset: drive reset=0 at cycle 6 -> busy, weight_read and outputs are all 0 immediately. A later start produces the correct basic-case results.

Source files
------------

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed dense layer: one signed MAC walks every neuron in turn,
// streaming weights and bias from an external synchronous ROM.
module dense_layer_sequencer #(
  parameter int    DATA_WIDTH  = 16,
  parameter int    FRAC_BITS   = 8,
  parameter int    NUM_INPUTS  = 16,
  parameter int    NUM_NEURONS = 16,
  parameter string ACTIVATION  = "RELU",
  localparam int   ROM_WORDS   = NUM_NEURONS * (NUM_INPUTS + 1),
  localparam int   AW          = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inputs_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  inputs,
  output logic [AW-1:0]                     weight_address,
  output logic                              weight_read,
  input  logic [DATA_WIDTH-1:0]             weight_data,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] outputs,
  output logic                              outputs_ready,
  output logic                              busy
);

  localparam int KW       = $clog2(NUM_INPUTS + 1);
  localparam int NW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int PW       = 2 * DATA_WIDTH;
  localparam int ACC_W    = PW + KW;
  localparam bit USE_RELU = (ACTIVATION == "RELU");

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

  state_t                         state, state_nx;
  logic [KW-1:0]                  k;
  logic [NW-1:0]                  n;
  logic [AW-1:0]                  base;
  logic                           last_k, last_n, start;

  logic signed [DATA_WIDTH-1:0]   in_p0 [NUM_INPUTS];
  logic                           vld_p1;
  logic [KW-1:0]                  k_p1;
  logic signed [DATA_WIDTH-1:0]   x_p1, w_p1;
  logic signed [PW-1:0]           prod_p1, term_p1;
  logic signed [ACC_W-1:0]        acc_p1, sum_p1;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] act(input logic signed [DATA_WIDTH-1:0] v);
    if (USE_RELU && v[DATA_WIDTH-1]) return '0;
    return v;
  endfunction

  assign start  = (state == IDLE) && inputs_ready;
  assign last_k = (k == KW'(NUM_INPUTS));
  assign last_n = (n == NW'(NUM_NEURONS - 1));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and control outputs; ROM address only driven while reading
  always_comb begin
    state_nx       = state;
    weight_read    = 1'b0;
    weight_address = '0;
    busy           = 1'b1;
    outputs_ready  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (inputs_ready) state_nx = RUN;
      end
      RUN: begin
        weight_read    = 1'b1;
        weight_address = base + AW'(k);
        if (last_k) state_nx = FINISH;
      end
      FINISH: state_nx = last_n ? DONE : RUN;
      DONE: begin
        outputs_ready = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: word counter k, neuron counter n and the neuron's ROM base address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      k    <= '0;
      n    <= '0;
      base <= '0;
    end else begin
      case (state)
        IDLE: if (inputs_ready) begin
          k    <= '0;
          n    <= '0;
          base <= '0;
        end
        RUN:    k <= k + KW'(1);
        FINISH: begin
          k <= '0;
          if (!last_n) begin
            n    <= n + NW'(1);
            base <= base + AW'(NUM_INPUTS + 1);
          end
        end
        default: ;
      endcase
    end
  end

  // p0: input vector captured once per run so upstream may change it freely
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) in_p0[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < NUM_INPUTS; i++) in_p0[i] <= inputs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // p1: valid flag and word index travel one cycle behind the issued address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      k_p1   <= '0;
    end else begin
      vld_p1 <= (state == RUN);
      k_p1   <= k;
    end
  end

  // p1: pick the latched input that matches the returning weight
  always_comb begin
    x_p1 = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (k_p1 == KW'(i)) x_p1 = in_p0[i];
  end

  assign w_p1    = weight_data;
  assign prod_p1 = PW'(x_p1) * PW'(w_p1);
  assign term_p1 = prod_p1 >>> FRAC_BITS;
  assign sum_p1  = acc_p1 + ACC_W'(w_p1);

  // p1: accumulate shifted products; the bias word lands during FINISH
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_p1 <= '0;
    end else begin
      case (state)
        IDLE:    if (inputs_ready) acc_p1 <= '0;
        RUN:     if (vld_p1 && (k_p1 < KW'(NUM_INPUTS))) acc_p1 <= acc_p1 + ACC_W'(term_p1);
        FINISH:  acc_p1 <= '0;
        default: ;
      endcase
    end
  end

  // p2: write the finished neuron's activated, saturated result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outputs <= '0;
    end else if (state == FINISH) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (n == NW'(i)) outputs[i*DATA_WIDTH +: DATA_WIDTH] <= act(sat(sum_p1));
    end
  end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: a RELU and a LINEAR instance run in lockstep
// from the same inputs and ROM contents, checked against an arithmetic model.
module tb_dense_layer_sequencer;

  localparam int DW   = 16;
  localparam int FB   = 8;
  localparam int NI   = 2;
  localparam int NN   = 2;
  localparam int ROMN = NN * (NI + 1);
  localparam int AW   = (ROMN > 1) ? $clog2(ROMN) : 1;
  localparam int LAST = NN * (NI + 2) + 1;

  logic                 clock, reset, inputs_ready;
  logic [NI*DW-1:0]     inputs;
  logic [AW-1:0]        addr0, addr1;
  logic                 rd0, rd1, ordy0, ordy1, busy0, busy1;
  logic [DW-1:0]        wd0, wd1;
  logic [NN*DW-1:0]     out0, out1;

  logic signed [DW-1:0] in_v [NI];
  logic signed [DW-1:0] rom  [ROMN];

  int n_vec = 0;
  int n_err = 0;

  dense_layer_sequencer #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_INPUTS(NI),
                          .NUM_NEURONS(NN), .ACTIVATION("RELU")) dut_relu (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
    .weight_address(addr0), .weight_read(rd0), .weight_data(wd0),
    .outputs(out0), .outputs_ready(ordy0), .busy(busy0));

  dense_layer_sequencer #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .NUM_INPUTS(NI),
                          .NUM_NEURONS(NN), .ACTIVATION("LINEAR")) dut_lin (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
    .weight_address(addr1), .weight_read(rd1), .weight_data(wd1),
    .outputs(out1), .outputs_ready(ordy1), .busy(busy1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    inputs = '0;
    for (int i = 0; i < NI; i++) inputs[i*DW +: DW] = in_v[i];
  end

  // Synchronous ROM: data returned one cycle after the read
  always @(posedge clock) begin
    if (rd0) wd0 <= rom[addr0];
    if (rd1) wd1 <= rom[addr1];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sv(input logic [NN*DW-1:0] v, input int n);
    logic signed [DW-1:0] t;
    t = v[n*DW +: DW];
    return longint'(t);
  endfunction

  function automatic longint ref_out(input int n, input bit relu);
    longint acc, p, hi, lo;
    acc = 0;
    hi  = (longint'(1) <<< (DW - 1)) - 1;
    lo  = -(longint'(1) <<< (DW - 1));
    for (int k = 0; k < NI; k++) begin
      p   = longint'(in_v[k]) * longint'(rom[n*(NI+1)+k]);
      acc = acc + (p >>> FB);
    end
    acc = acc + longint'(rom[n*(NI+1)+NI]);
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  function automatic logic signed [DW-1:0] rnd();
    if ($urandom_range(0, 3) == 0) return DW'($urandom);
    return DW'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  task automatic set_basic();
    in_v[0] = 16'sd256; in_v[1] = 16'sd512;
    rom[0] = 16'sd128;  rom[1] = 16'sd64; rom[2] = 16'sd128;
    rom[3] = -16'sd256; rom[4] = 16'sd0;  rom[5] = 16'sd0;
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_relu0"}, sv(out0, 0), 384);
    chk({tag, "_relu1"}, sv(out0, 1), 0);
    chk({tag, "_lin0"},  sv(out1, 0), 384);
    chk({tag, "_lin1"},  sv(out1, 1), -256);
  endtask

  // One run: start at edge 0, then check every cycle up to the idle cycle
  // after DONE. Optional stray start pulse at poke_cyc, optional reset at abort_cyc.
  task automatic run(input int poke_cyc, input int abort_cyc);
    longint er [NN];
    longint el [NN];
    int j, nn;
    for (int n = 0; n < NN; n++) begin
      er[n] = ref_out(n, 1'b1);
      el[n] = ref_out(n, 1'b0);
    end
    @(negedge clock); inputs_ready = 1'b1;
    @(negedge clock); inputs_ready = 1'b0;
    for (int c = 1; c <= LAST + 1; c++) begin
      if (c == abort_cyc) begin
        reset = 1'b0;
        #1;
        chk("abort_busy",  busy0, 0);
        chk("abort_read",  rd0,   0);
        chk("abort_ready", ordy0, 0);
        chk("abort_out_relu", longint'(out0), 0);
        chk("abort_out_lin",  longint'(out1), 0);
        @(negedge clock); reset = 1'b1;
        return;
      end
      j  = (c - 1) % (NI + 2);
      nn = (c - 1) / (NI + 2);
      chk("busy",      busy0, longint'(c <= LAST));
      chk("ready",     ordy0, longint'(c == LAST));
      chk("ready_lin", ordy1, longint'(c == LAST));
      if (c < LAST) begin
        chk("read", rd0, longint'(j <= NI));
        if (j <= NI) chk("addr", addr0, nn * (NI + 1) + j);
      end else begin
        chk("read_idle", rd0, 0);
      end
      if (c == LAST) begin
        for (int n = 0; n < NN; n++) begin
          chk("out_relu", sv(out0, n), er[n]);
          chk("out_lin",  sv(out1, n), el[n]);
        end
      end
      if (c == poke_cyc) begin
        inputs_ready = 1'b1;
        for (int i = 0; i < NI; i++) in_v[i] = rnd();
      end
      if (poke_cyc > 0 && poke_cyc < LAST && c == poke_cyc + 1) inputs_ready = 1'b0;
      if (c <= LAST) @(negedge clock);
    end
  endtask

  initial begin
    longint er [NN];
    longint el [NN];
    int cnt;
    bit seen;

    reset = 1'b0;
    inputs_ready = 1'b0;
    for (int i = 0; i < NI; i++) in_v[i] = '0;
    for (int i = 0; i < ROMN; i++) rom[i] = '0;
    #1;
    chk("rst_busy",  busy0, 0);
    chk("rst_read",  rd0,   0);
    chk("rst_addr",  addr0, 0);
    chk("rst_ready", ordy0, 0);
    chk("rst_out",   longint'(out0), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Basic case
    set_basic();
    run(0, 0);
    chk_basic("basic");

    // Start request while busy is ignored and not queued
    run(4, 0);
    chk_basic("ignore");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("ignore_idle", busy0, 0);
    end

    // Saturation in both directions
    for (int i = 0; i < NI; i++) in_v[i] = 16'sh7FFF;
    for (int i = 0; i <= NI; i++) begin
      rom[i]        = 16'sh7FFF;
      rom[NI+1+i]   = -16'sh8000;
    end
    run(0, 0);
    chk("sat_relu0", sv(out0, 0), 32767);
    chk("sat_relu1", sv(out0, 1), 0);
    chk("sat_lin0",  sv(out1, 0), 32767);
    chk("sat_lin1",  sv(out1, 1), -32768);

    // Reset in the middle of a run, then a clean run
    set_basic();
    run(0, 6);
    chk("post_abort_busy", busy0, 0);
    run(0, 0);
    chk_basic("after_abort");

    // inputs_ready raised in DONE and held: ignored in DONE, restart after one idle cycle
    run(LAST, 0);
    for (int n = 0; n < NN; n++) begin
      er[n] = ref_out(n, 1'b1);
      el[n] = ref_out(n, 1'b0);
    end
    @(negedge clock);
    inputs_ready = 1'b0;
    chk("restart_busy", busy0, 1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clock);
      cnt++;
      seen = ordy0;
    end
    chk("restart_seen", longint'(seen), 1);
    chk("restart_lat",  cnt, LAST - 1);
    for (int n = 0; n < NN; n++) begin
      chk("restart_relu", sv(out0, n), er[n]);
      chk("restart_lin",  sv(out1, n), el[n]);
    end

    // Randomized runs
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NI; i++)   in_v[i] = rnd();
      for (int i = 0; i < ROMN; i++) rom[i]  = rnd();
      run(0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
